// File: rtl/camo_key_loader.sv
// camo_key_loader: serial select-key loader with per-cell range check, settle sequencing and lock.
// Define CAMO_KEY_PARITY_EN to accept a trailing even-parity bit checked alongside the cell mask.
module camo_key_loader #(
    parameter int                       NUM_CELLS  = 6,
    parameter logic [NUM_CELLS*4-1:0]   ALLOW_MASK = {NUM_CELLS{4'hF}},
    parameter int                       SETTLE_CYC = 4,
    localparam int                      KEY_W      = NUM_CELLS * 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_start,
    input  logic             i_key_valid,
    input  logic             i_key_bit,
    output logic             o_key_ready,
    input  logic             i_lock_req,
    output logic [KEY_W-1:0] o_s_key,
    output logic             o_load_done,
    output logic             o_load_err,
    output logic             o_busy,
    output logic             o_locked
);

`ifdef CAMO_KEY_PARITY_EN
    localparam int SH_W = KEY_W + 1;
`else
    localparam int SH_W = KEY_W;
`endif
    localparam int CNT_W = $clog2(KEY_W + 2);

    typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_CHECK, ST_SETTLE, ST_LOCKED} state_t;

    state_t             r_state;
    logic [SH_W-1:0]    r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_set;
    logic [NUM_CELLS-1:0] w_cell_ok;
    logic               w_key_ok;

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        logic [3:0] w_m;
        assign w_m          = ALLOW_MASK[4*g +: 4];
        assign w_cell_ok[g] = w_m[r_shadow[2*g +: 2]];
    end

`ifdef CAMO_KEY_PARITY_EN
    assign w_key_ok = (&w_cell_ok) & ~(^r_shadow);
`else
    assign w_key_ok = &w_cell_ok;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_set       <= '0;
            o_s_key     <= '0;
            o_key_ready <= 1'b0;
            o_load_done <= 1'b0;
            o_load_err  <= 1'b0;
            o_busy      <= 1'b0;
            o_locked    <= 1'b0;
        end else begin
            o_load_done <= 1'b0;
            o_load_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load_start) begin
                        r_state     <= ST_SHIFT;
                        r_cnt       <= '0;
                        o_key_ready <= 1'b1;
                        o_busy      <= 1'b1;
                    end else if (i_lock_req) begin
                        r_state  <= ST_LOCKED;
                        o_locked <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // new bit enters the MSB so the first bit ends up in s_key[0]
                    if (i_key_valid && o_key_ready) begin
                        r_shadow <= {i_key_bit, r_shadow[SH_W-1:1]};
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(SH_W - 1)) begin
                            r_state     <= ST_CHECK;
                            o_key_ready <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_key_ok) begin
                        o_s_key <= r_shadow[KEY_W-1:0];
                        r_set   <= '0;
                        r_state <= ST_SETTLE;
                    end else begin
                        o_load_err <= 1'b1;
                        o_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_set == 4'(SETTLE_CYC - 1)) begin
                        o_load_done <= 1'b1;
                        o_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_set <= r_set + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_camo_key_loader.sv
// tb_camo_key_loader: randomized key loads against a cycle-level behavioural model of camo_key_loader.
module tb_camo_key_loader;
    localparam int          SETTLE = 4;
    localparam logic [23:0] MASK   = 24'hFFF7FF;
`ifdef CAMO_KEY_PARITY_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_load_start = 1'b0;
    logic        i_key_valid = 1'b0;
    logic        i_key_bit = 1'b0;
    logic        i_lock_req = 1'b0;
    logic        o_key_ready;
    logic [11:0] o_s_key;
    logic        o_load_done;
    logic        o_load_err;
    logic        o_busy;
    logic        o_locked;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] m_key = '0;

    camo_key_loader #(.NUM_CELLS(6), .ALLOW_MASK(MASK), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .i_load_start(i_load_start), .i_key_valid(i_key_valid),
        .i_key_bit(i_key_bit), .o_key_ready(o_key_ready), .i_lock_req(i_lock_req),
        .o_s_key(o_s_key), .o_load_done(o_load_done), .o_load_err(o_load_err),
        .o_busy(o_busy), .o_locked(o_locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic bit allowed(input logic [11:0] k);
        for (int c = 0; c < 6; c++)
            if (!MASK[4*c + int'((k >> (2*c)) & 12'd3)]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [11:0] key, input bit flip, input bit gaps);
        logic [12:0] b;
        bit          ok;
        int          n;
        int          g;
        b  = {^key ^ flip, key};
        ok = allowed(key) && (NB == 12 || !flip);
        if (gaps) repeat (3) begin
            i_key_valid = 1'b1;
            i_key_bit   = 1'($urandom);
            tick();
        end
        i_key_valid  = 1'b0;
        i_load_start = 1'b1;
        i_lock_req   = 1'($urandom_range(0, 1));
        tick();
        i_load_start = 1'b0;
        i_lock_req   = 1'b0;
        chk("ready_on", o_key_ready, 1);
        chk("busy_on", o_busy, 1);
        chk("start_beats_lock", o_locked, 0);
        n = 0;
        g = 0;
        while (n < NB && g < 1000) begin
            chk("ready_in_shift", o_key_ready, 1);
            i_key_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_key_bit    = i_key_valid ? b[n] : 1'($urandom);
            i_load_start = 1'($urandom);
            i_lock_req   = 1'($urandom);
            tick();
            if (i_key_valid) n++;
            g++;
        end
        i_key_valid  = 1'b0;
        i_load_start = 1'b0;
        i_lock_req   = 1'b0;
        if (g >= 1000) chk("shift_budget", g, 0);
        chk("ready_off", o_key_ready, 0);
        chk("skey_hold_check", o_s_key, m_key);
        tick();
        if (ok) begin
            m_key = key;
            chk("skey_new", o_s_key, m_key);
            chk("err_quiet", o_load_err, 0);
            repeat (SETTLE) begin
                chk("done_early", o_load_done, 0);
                chk("busy_settle", o_busy, 1);
                tick();
            end
            chk("done_pulse", o_load_done, 1);
            chk("busy_after", o_busy, 0);
            chk("skey_done", o_s_key, m_key);
            tick();
            chk("done_once", o_load_done, 0);
        end else begin
            chk("err_pulse", o_load_err, 1);
            chk("skey_kept", o_s_key, m_key);
            chk("busy_err", o_busy, 0);
            chk("done_err", o_load_done, 0);
            tick();
            chk("err_once", o_load_err, 0);
        end
        chk("ready_idle", o_key_ready, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_skey"}, o_s_key, 0);
        chk({tag, "_flags"}, {o_key_ready, o_load_done, o_load_err, o_busy, o_locked}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        load_key(12'hA5C, 1'b0, 1'b0);
        load_key(12'hA7C, 1'b0, 1'b0);
        load_key(12'h3C1, 1'b0, 1'b0);
        load_key(12'h6D2, 1'b0, 1'b0);
        load_key(12'h3C1, 1'b0, 1'b1);
        repeat (14) load_key(12'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
`ifdef CAMO_KEY_PARITY_EN
        load_key(12'h123, 1'b0, 1'b0);
        load_key(12'hA5C, 1'b1, 1'b0);
        load_key(12'hA5C, 1'b0, 1'b0);
`endif
        load_key(12'hA5C, 1'b0, 1'b0);
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        repeat (7) begin
            i_key_valid = 1'b1;
            i_key_bit   = 1'($urandom);
            tick();
        end
        i_key_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_all_zero("async_rst");
        m_key = '0;
        tick();
        rst_n = 1'b1;
        tick();
        load_key(12'h5A3, 1'b0, 1'b1);
        i_lock_req = 1'b1;
        tick();
        i_lock_req = 1'b0;
        chk("locked_on", o_locked, 1);
        chk("locked_busy", o_busy, 0);
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        repeat (NB + 2) begin
            chk("locked_ready", o_key_ready, 0);
            i_key_valid = 1'b1;
            i_key_bit   = 1'($urandom);
            tick();
        end
        i_key_valid = 1'b0;
        repeat (SETTLE + 2) tick();
        chk("locked_skey", o_s_key, m_key);
        chk("locked_stay", o_locked, 1);
        chk("locked_quiet", {o_load_done, o_load_err, o_busy}, 0);
        rst_n = 1'b0;
        #2;
        chk_all_zero("unlock_rst");
        m_key = '0;
        tick();
        rst_n = 1'b1;
        tick();
        load_key(12'h0F0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
